// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-back arbiter: three requesters (ALU, MEM, STK) share one
// registered register-file write port with a single-entry output buffer.
module gpr_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req_valid,
  input  logic [3*REG_W-1:0]  req_reg,
  input  logic [3*DATA_W-1:0] req_data,
  output logic [2:0]          req_ready,
  input  logic                flush,
  output logic                wr_valid,
  output logic [REG_W-1:0]    wr_reg,
  output logic [DATA_W-1:0]   wr_data,
  input  logic                wr_ready,
  output logic [15:0]         grant_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  rr_ptr;
  logic        can_accept;
  logic        found;
  logic        accept;
  logic [1:0]  win_idx;
  logic [1:0]  idx;

  assign can_accept = (state == EMPTY) || (wr_ready && !flush);

  // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first asserted request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 2'd0;
    idx     = 2'd0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = 2'((32'(rr_ptr) + k) % 3);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Flush also blocks acceptance while EMPTY so a flush cycle never admits a write.
  assign accept = can_accept && !flush && !reset && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  assign wr_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      wr_reg    <= '0;
      wr_data   <= '0;
      rr_ptr    <= 2'd0;
      grant_cnt <= '0;
    end else if (accept) begin
      state   <= FULL;
      wr_reg  <= req_reg[32'(win_idx)*REG_W +: REG_W];
      wr_data <= req_data[32'(win_idx)*DATA_W +: DATA_W];
      rr_ptr  <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      if (grant_cnt != '1) grant_cnt <= grant_cnt + 16'd1;
    end else if (flush || (state == FULL && wr_ready)) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [8:0]  req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        flush;
  logic        wr_valid;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [15:0] grant_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  gpr_wb_arbiter #(.DATA_W(32), .REG_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .wr_valid  (wr_valid),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic v, input logic [2:0] r,
                        input logic [31:0] d);
    chk({tag, "_wr_valid"}, 32'(v), 32'(wr_valid));
    chk({tag, "_wr_reg"}, 32'(wr_reg), 32'(r));
    chk({tag, "_wr_data"}, wr_data, d);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_ready = 1'b1;
    req_valid = 3'b111;
    req_reg  = {3'd0, 3'd0, 3'd3};
    req_data = {32'h0, 32'h0, 32'h0000_0888};

    // Reset state, requests blocked while reset is high.
    drive; drive; sample;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk_wr("rst", 1'b0, 3'd0, 32'h0);
    chk("rst_cnt", 32'(grant_cnt), 32'h0);

    // Single ALU write.
    drive; reset = 1'b0; req_valid = 3'b001; sample;
    chk("alu_ready", 32'(req_ready), 32'h1);
    drive; req_valid = 3'b000; sample;
    chk_wr("alu", 1'b1, 3'd3, 32'h0000_0888);
    chk("alu_cnt", 32'(grant_cnt), 32'd1);

    // Round-robin over all three from a fresh reset.
    drive; reset = 1'b1; sample;
    drive; reset = 1'b0;
    req_reg  = {3'd7, 3'd5, 3'd1};
    req_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    req_valid = 3'b111; sample;
    chk("rr_c1_ready", 32'(req_ready), 32'b001);
    chk("rr_c1_wr_valid", 32'(wr_valid), 32'h0);
    drive; sample;
    chk("rr_c2_ready", 32'(req_ready), 32'b010);
    chk_wr("rr_c2", 1'b1, 3'd1, 32'hAAAA_0001);
    drive; sample;
    chk("rr_c3_ready", 32'(req_ready), 32'b100);
    chk_wr("rr_c3", 1'b1, 3'd5, 32'hBBBB_0002);
    drive; sample;
    chk("rr_c4_ready", 32'(req_ready), 32'b001);
    chk_wr("rr_c4", 1'b1, 3'd7, 32'hCCCC_0003);
    drive; req_valid = 3'b000; sample;
    chk_wr("rr_c5", 1'b1, 3'd1, 32'hAAAA_0001);
    chk("rr_c5_cnt", 32'(grant_cnt), 32'd4);

    // Backpressure: MEM accepted, then wr_ready low for three cycles.
    drive; req_valid = 3'b010; sample;
    chk("bp_accept", 32'(req_ready), 32'b010);
    drive; wr_ready = 1'b0; req_data[63:32] = 32'hDDDD_0004; sample;
    chk("bp_hold1_ready", 32'(req_ready), 32'h0);
    chk_wr("bp_hold1", 1'b1, 3'd5, 32'hBBBB_0002);
    drive; sample;
    chk("bp_hold2_ready", 32'(req_ready), 32'h0);
    chk_wr("bp_hold2", 1'b1, 3'd5, 32'hBBBB_0002);
    drive; sample;
    chk("bp_hold3_ready", 32'(req_ready), 32'h0);
    chk_wr("bp_hold3", 1'b1, 3'd5, 32'hBBBB_0002);
    drive; wr_ready = 1'b1; sample;
    chk("bp_regrant", 32'(req_ready), 32'b010);
    drive; req_valid = 3'b000; sample;
    chk_wr("bp_second", 1'b1, 3'd5, 32'hDDDD_0004);
    chk("bp_cnt", 32'(grant_cnt), 32'd6);

    // Flush while FULL with STK requesting: rr_ptr must stay at MEM.
    drive; wr_ready = 1'b0; req_valid = 3'b001; sample;
    chk("fl_alu_grant", 32'(req_ready), 32'b001);
    drive; req_valid = 3'b100; flush = 1'b1; sample;
    chk("fl_ready", 32'(req_ready), 32'h0);
    chk("fl_full", 32'(wr_valid), 32'h1);
    drive; flush = 1'b0; req_valid = 3'b111; sample;
    chk("fl_empty", 32'(wr_valid), 32'h0);
    chk("fl_cnt", 32'(grant_cnt), 32'd7);
    chk("fl_wr_reg_hold", 32'(wr_reg), 32'd1);
    chk("fl_ptr_hold", 32'(req_ready), 32'b010);

    // Reset while FULL and stalled.
    drive; reset = 1'b1; sample;
    chk("rm_ready", 32'(req_ready), 32'h0);
    chk("rm_full", 32'(wr_valid), 32'h1);
    drive; reset = 1'b0; sample;
    chk_wr("rm_after", 1'b0, 3'd0, 32'h0);
    chk("rm_cnt", 32'(grant_cnt), 32'h0);
    chk("rm_alu_first", 32'(req_ready), 32'b001);
    drive; req_valid = 3'b000; wr_ready = 1'b1; sample;
    chk_wr("rm_alu_wr", 1'b1, 3'd1, 32'hAAAA_0001);

    // Counter saturation.
    drive; sample;
    force dut.grant_cnt = 16'hFFFD;
    #1;
    release dut.grant_cnt;
    drive; req_valid = 3'b001; sample;
    chk("sat_c0", 32'(grant_cnt), 32'h0000_FFFD);
    drive; sample;
    chk("sat_c1", 32'(grant_cnt), 32'h0000_FFFE);
    drive; sample;
    chk("sat_c2", 32'(grant_cnt), 32'h0000_FFFF);
    drive; req_valid = 3'b000; sample;
    chk("sat_c3", 32'(grant_cnt), 32'h0000_FFFF);
    chk("sat_wr_valid", 32'(wr_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, write-data width in bits.
REQ-002 Parameter REG_W, default 3, register-index width (8 GPRs: 0=eax..7=edi).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  3  per-requester write request; bit0=ALU, bit1=MEM, bit2=STK.
REQ-006 req_reg  input  3*REG_W  per-requester target index; slice i belongs to requester i.
REQ-007 req_data  input  3*DATA_W  per-requester write data; slice i belongs to requester i.
REQ-008 req_ready  output  3  one-hot-or-zero accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-009 flush  input  1  drops the pending output write; does not affect requesters.
REQ-010 wr_valid  output  1  register-file write strobe, registered.
REQ-011 wr_reg  output  REG_W  register-file write index, registered.
REQ-012 wr_data  output  DATA_W  register-file write data, registered.
REQ-013 wr_ready  input  1  register file consumes the write when wr_valid and wr_ready are both high at an edge.
REQ-014 grant_cnt  output  16  count of accepted transfers, saturating at 16'hFFFF.

Function
REQ-015 The block SHALL hold at most one pending write in an output register (state EMPTY or FULL).
REQ-016 can_accept SHALL equal (state==EMPTY) or (wr_ready and not flush); can_accept is combinational.
REQ-017 req_ready SHALL be zero when can_accept is low or reset is high; otherwise exactly the round-robin winner among asserted req_valid bits is high.
REQ-018 Round-robin: search starts at pointer rr_ptr (0..2) and proceeds rr_ptr, rr_ptr+1, rr_ptr+2 modulo 3; the first asserted req_valid wins.
REQ-019 On a transfer from requester i, rr_ptr SHALL become (i+1) mod 3; with no transfer rr_ptr SHALL hold.
REQ-020 On a transfer, wr_reg/wr_data SHALL load the winner's slices and state SHALL be FULL at the next edge (latency 1 cycle from accept to wr_valid).
REQ-021 FULL with wr_ready high and no new transfer: state SHALL become EMPTY; FULL with wr_ready low: outputs SHALL hold unchanged.
REQ-022 FULL with wr_ready high and a new transfer in the same cycle: state SHALL stay FULL with new contents (back-to-back, one write per cycle).
REQ-023 flush high: state SHALL become EMPTY, no transfer is accepted that cycle, rr_ptr and grant_cnt hold; a write consumed in the same cycle still counts as written.
REQ-024 wr_valid SHALL equal (state==FULL); wr_reg/wr_data are don't-care while EMPTY but SHALL not change except on a transfer or reset.
REQ-025 Two requesters targeting the same register are not merged; each is written in grant order.
REQ-026 grant_cnt SHALL increment by 1 per transfer and hold at 16'hFFFF.
REQ-027 req_valid deasserted without a transfer is legal; the block keeps no request memory.

Reset
REQ-028 While reset is high at an edge: state=EMPTY, wr_valid=0, wr_reg=0, wr_data=0, rr_ptr=0, grant_cnt=0; req_ready=0 combinationally.
REQ-029 Reset SHALL take priority over flush, wr_ready and all requests, including mid-transfer (pending write discarded).
REQ-030 First edge after reset deasserts: arbitration starts at ALU.

Verification
REQ-031 After reset, ALU only, req_reg=3, data=32'h0000_0888, wr_ready=1 -> req_ready=3'b001, next cycle wr_valid=1, wr_reg=3, wr_data=32'h0000_0888, grant_cnt=1.
REQ-032 All three valid continuously, wr_ready=1 -> grants ALU, MEM, STK, ALU on 4 consecutive cycles; wr_valid high every cycle after the first.
REQ-033 MEM valid, wr_ready=0 for 3 cycles after first accept -> first write held stable 3 cycles, req_ready=0 throughout, second grant on the cycle wr_ready returns.
REQ-034 FULL, flush=1 with STK valid -> next cycle wr_valid=0, req_ready=0 during flush cycle, rr_ptr unchanged.
REQ-035 Reset asserted while FULL with wr_ready=0 -> next cycle wr_valid=0, grant_cnt=0, next grant goes to ALU.
REQ-036 Preload 16'hFFFE transfers (or force) then 3 more -> grant_cnt stays 16'hFFFF.
